// File: rtl/cdc_stable_capture_pkg.sv
// Shared types and helpers for the stable-capture stage.
// Used by the top and by anything sizing its settle counter.
package cdc_pkg;

  typedef enum logic {
    IDLE,
    SETTLE
  } stab_state_t;

  localparam int GLITCH_CNT_W = 8;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cdc_stable_capture_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over a same-cycle increment.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cdc_stable_capture.sv
// Qualifies a synchronized multi-bit word: publishes it only after it
// has held for STABLE_CYCLES samples, and counts abandoned settles.
module cdc_stable_capture
  import cdc_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 1,
  parameter int                    STABLE_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] RST_VAL       = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    upd,
  output logic [DATA_WIDTH-1:0]   rise,
  output logic [DATA_WIDTH-1:0]   fall,
  input  logic                    glitch_clr,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  stab_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  upd_q, upd_d;
  logic [DATA_WIDTH-1:0] rise_q, rise_d;
  logic [DATA_WIDTH-1:0] fall_q, fall_d;
  logic                  glitch_inc;
  logic                  commit;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    upd_d      = 1'b0;
    rise_d     = '0;
    fall_d     = '0;
    glitch_inc = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (din != dout_q) begin
          if (STABLE_CYCLES == 1) begin
            commit = 1'b1;
          end else begin
            cand_d  = din;
            cnt_d   = ONE;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        // Falling back to the published word means the change was a transient.
        if (din == dout_q) begin
          state_d    = IDLE;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (din != cand_q) begin
          cand_d = din;
          cnt_d  = ONE;
        end else if (cnt_q == LAST) begin
          commit  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      dout_d = din;
      upd_d  = 1'b1;
      rise_d = din & ~dout_q;
      fall_d = ~din & dout_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= RST_VAL;
      upd_q   <= 1'b0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      upd_q   <= upd_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  sat_cnt #(
    .W (GLITCH_CNT_W)
  ) u_glitch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (glitch_clr),
    .inc   (glitch_inc),
    .cnt   (glitch_cnt)
  );

  assign dout = dout_q;
  assign upd  = upd_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: doc/cdc_stable_capture.md
Name: cdc_stable_capture

Overview:
- Sits directly downstream of the single-bit-array synchronizer, in the destination clock domain.
- Each bit of that synchronizer settles independently, so a multi-bit control word can appear torn for a few cycles.
- This block accepts the synchronized word only after it has held constant for a programmable number of cycles.
- It then publishes the word with a one-cycle update strobe and per-bit rise/fall masks, and counts rejected transients.

Parameters:
- DATA_WIDTH, 1: width of din/dout/rise/fall; range 1-1024.
- STABLE_CYCLES, 4: consecutive identical samples required before commit; range 1-255.
- RST_VAL, 0: reset value of dout (DATA_WIDTH bits).

Ports:
- clk  input  1  destination-domain clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DATA_WIDTH  word from the synchronizer output; already registered upstream, so it is not re-registered here.
- dout  output  DATA_WIDTH  qualified (stable) word; registered.
- upd  output  1  one-cycle pulse, coincident with each dout change.
- rise  output  DATA_WIDTH  bits going 0->1 in this commit; valid only while upd=1, else 0.
- fall  output  DATA_WIDTH  bits going 1->0 in this commit; valid only while upd=1, else 0.
- glitch_clr  input  1  synchronous clear of glitch_cnt.
- glitch_cnt  output  8  saturating count of abandoned settles.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: dout=RST_VAL, upd=0, rise=0, fall=0, glitch_cnt=0, state=IDLE, cnt=0, cand=0.
- Internal registers:
  - state in {IDLE, SETTLE}.
  - cand: candidate word, DATA_WIDTH bits.
  - cnt: width clog2(STABLE_CYCLES+1).
- IDLE:
  - din==dout: stay.
  - din!=dout and STABLE_CYCLES==1: commit immediately.
  - din!=dout otherwise: cand<=din, cnt<=1, go SETTLE.
- SETTLE, priority order:
  1. din==dout: abandon, go IDLE, cnt<=0, glitch_cnt increments.
  2. din!=cand: cand<=din, cnt<=1, stay; no glitch count.
  3. din==cand and cnt==STABLE_CYCLES-1: commit, go IDLE.
  4. Otherwise: cnt<=cnt+1.
- Commit (registered, all on the same edge):
  - dout<=new word; upd<=1.
  - rise<=new & ~old_dout; fall<=~new & old_dout.
- Default: upd, rise and fall return to 0 on the edge after a commit.
- Latency: a value must be sampled on STABLE_CYCLES consecutive edges. dout/upd change on the last of those edges.
- Back-to-back commits are legal: upd may be high in consecutive cycles only when STABLE_CYCLES==1.
- glitch_cnt: saturates at 255 and never wraps. glitch_clr has priority over a simultaneous increment, so the result is 0.
- Reset mid-SETTLE: the pending candidate is discarded and no upd is emitted. After release, if din!=RST_VAL, a normal settle runs and produces upd.
- No handshake back-pressure: the consumer must sample dout/rise/fall in the upd cycle.

Decomposition:
- Shared package cdc_pkg:
  - typedef enum logic {IDLE, SETTLE} stab_state_t.
  - constant GLITCH_CNT_W = 8.
  - function cnt_width(n) returning clog2(n+1).
- One sub-module: sat_cnt, a parameterised saturating up-counter with synchronous clear (clear wins), used for glitch_cnt and reusable elsewhere.

Test Plan:
- Reset/commit (W=8, STABLE_CYCLES=4, RST_VAL=0): hold rst_n=0 with din=8'hA5 -> dout=0, upd=0. Release -> on the 4th edge of sampling A5: dout=A5, upd=1 for exactly one cycle, rise=A5, fall=00.
- Glitch rejection: dout=A5; din=5A for 2 cycles, then A5 -> dout stays A5, upd never asserts, glitch_cnt=1.
- Candidate replace: dout=00; din=01 for 2 cycles, then 03 held -> dout=03 on the 4th edge after 03 arrives, no intermediate 01 commit, glitch_cnt unchanged, rise=03.
- Saturation/clear: generate 300 glitches -> glitch_cnt=255. Assert glitch_clr in the same cycle as a glitch -> glitch_cnt=0 next cycle.
- STABLE_CYCLES=1: din toggles 00->FF->00 on consecutive cycles -> dout follows with one edge of latency, upd high two consecutive cycles, rise=FF then fall=FF.
- Reset mid-settle (STABLE_CYCLES=4): din=3C for 2 cycles, assert rst_n=0 asynchronously -> dout=00 immediately, no upd. Release with din=3C held -> commit 3C after 4 edges.
